// File: rtl/sync_fifo_ctrl.sv
// sync_fifo_ctrl: single-clock FIFO with registered occupancy, threshold flags and sticky error flags.
// Requests are gated for the first edge after reset release so a release-cycle request is ignored.
module sync_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int AF_LEVEL   = 12,
    parameter int AE_LEVEL   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  write_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  read_en,
    input  logic                  clear_err,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] L_DEPTH = DEPTH[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] L_AF    = AF_LEVEL[ADDR_WIDTH:0];
    localparam logic [ADDR_WIDTH:0] L_AE    = AE_LEVEL[ADDR_WIDTH:0];

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_dout;
    logic [ADDR_WIDTH:0]   r_wr_ptr, r_rd_ptr, r_count, w_wr_nxt, w_rd_nxt;
    logic                  r_run, r_dv, r_ovf, r_udf, w_wr_acc, w_rd_acc;

    assign full         = r_count == L_DEPTH;
    assign empty        = r_count == '0;
    assign almost_full  = r_count >= L_AF;
    assign almost_empty = r_count <= L_AE;
    assign count        = r_count;
    assign data_out     = r_dout;
    assign data_valid   = r_dv;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;

    assign w_wr_acc = r_run & write_en & ~full;
    assign w_rd_acc = r_run & read_en & ~empty;
    assign w_wr_nxt = r_wr_ptr + (ADDR_WIDTH+1)'(w_wr_acc);
    assign w_rd_nxt = r_rd_ptr + (ADDR_WIDTH+1)'(w_rd_acc);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_run    <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_dout   <= '0;
            r_dv     <= 1'b0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            r_run    <= 1'b1;
            r_wr_ptr <= w_wr_nxt;
            r_rd_ptr <= w_rd_nxt;
            r_count  <= w_wr_nxt - w_rd_nxt;
            r_dv     <= w_rd_acc;
            if (w_rd_acc) r_dout <= r_mem[r_rd_ptr[ADDR_WIDTH-1:0]];
            // a new error takes priority over a coincident clear
            r_ovf    <= (r_run & write_en & full) | (r_ovf & ~clear_err);
            r_udf    <= (r_run & read_en & empty) | (r_udf & ~clear_err);
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_acc) r_mem[r_wr_ptr[ADDR_WIDTH-1:0]] <= data_in;
    end
endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// tb_sync_fifo_ctrl: table-driven checks on the default FIFO plus hand-written reset and 32x64 sequences.
module tb_sync_fifo_ctrl;
    logic        clk, rst_n;
    logic        write_en, read_en, clear_err;
    logic [7:0]  data_in, data_out;
    logic        data_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [4:0]  count;

    logic        we2, re2, ce2;
    logic [31:0] din2, dout2;
    logic        dv2, full2, empty2, af2, ae2, ovf2, udf2;
    logic [6:0]  count2;

    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        logic       we;
        logic [7:0] din;
        logic       re;
        logic       ce;
        int         cnt;
        logic [7:0] dout;
        logic       dv;
        logic       ovf;
        logic       udf;
    } vec_t;
    vec_t vecs[$];

    sync_fifo_ctrl dut (
        .clk(clk), .rst_n(rst_n), .write_en(write_en), .data_in(data_in),
        .read_en(read_en), .clear_err(clear_err), .data_out(data_out),
        .data_valid(data_valid), .full(full), .empty(empty),
        .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
        .overflow(overflow), .underflow(underflow)
    );

    sync_fifo_ctrl #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .AF_LEVEL(60), .AE_LEVEL(0)) dut2 (
        .clk(clk), .rst_n(rst_n), .write_en(we2), .data_in(din2),
        .read_en(re2), .clear_err(ce2), .data_out(dout2),
        .data_valid(dv2), .full(full2), .empty(empty2),
        .almost_full(af2), .almost_empty(ae2), .count(count2),
        .overflow(ovf2), .underflow(udf2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic chk_main(input string t, input int cnt, input logic [7:0] dout,
                            input logic dv, input logic ovf, input logic udf);
        chk({t, " count"}, 64'(count), 64'(cnt));
        chk({t, " full"}, 64'(full), 64'(cnt == 16));
        chk({t, " empty"}, 64'(empty), 64'(cnt == 0));
        chk({t, " almost_full"}, 64'(almost_full), 64'(cnt >= 12));
        chk({t, " almost_empty"}, 64'(almost_empty), 64'(cnt <= 4));
        chk({t, " data_out"}, 64'(data_out), 64'(dout));
        chk({t, " data_valid"}, 64'(data_valid), 64'(dv));
        chk({t, " overflow"}, 64'(overflow), 64'(ovf));
        chk({t, " underflow"}, 64'(underflow), 64'(udf));
    endtask

    task automatic add(input logic we, input int din, input logic re, input logic ce,
                       input int cnt, input int dout, input logic dv, input logic ovf, input logic udf);
        vec_t v;
        v.we = we; v.din = 8'(din); v.re = re; v.ce = ce; v.cnt = cnt;
        v.dout = 8'(dout); v.dv = dv; v.ovf = ovf; v.udf = udf;
        vecs.push_back(v);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; write_en = 1'b0; read_en = 1'b0; clear_err = 1'b0; data_in = '0;
        we2 = 1'b0; re2 = 1'b0; ce2 = 1'b0; din2 = '0;

        // fill, overfill, drain, overdrain
        for (int k = 1; k <= 16; k++) add(1, k, 0, 0, k, 'h00, 0, 0, 0);
        add(1, 'hEE, 0, 0, 16, 'h00, 0, 1, 0);
        for (int k = 1; k <= 16; k++) add(0, 0, 1, 0, 16 - k, k, 1, 1, 0);
        add(0, 0, 1, 0, 0, 'h10, 0, 1, 1);
        add(0, 0, 0, 1, 0, 'h10, 0, 0, 0);
        // steady state at count 8
        for (int i = 0; i < 8; i++) add(1, 'h20 + i, 0, 0, i + 1, 'h10, 0, 0, 0);
        for (int j = 0; j < 40; j++) add(1, 'h28 + j, 1, 0, 8, 'h20 + j, 1, 0, 0);
        for (int i = 0; i < 8; i++) add(0, 0, 1, 0, 7 - i, 'h48 + i, 1, 0, 0);
        // both requests at empty / at full, clear_err interactions
        add(1, 'h55, 1, 0, 1, 'h4F, 0, 0, 1);
        add(0, 0, 0, 1, 1, 'h4F, 0, 0, 0);
        for (int i = 0; i < 15; i++) add(1, 'h60 + i, 0, 0, 2 + i, 'h4F, 0, 0, 0);
        add(1, 'h99, 1, 0, 15, 'h55, 1, 1, 0);
        add(1, 'h70, 0, 0, 16, 'h55, 0, 1, 0);
        add(0, 0, 0, 1, 16, 'h55, 0, 0, 0);
        add(1, 'h71, 0, 1, 16, 'h55, 0, 1, 0);
        add(0, 0, 0, 1, 16, 'h55, 0, 0, 0);

        #12;
        chk_main("reset", 0, 8'h00, 0, 0, 0);
        rst_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            write_en = vecs[i].we; data_in = vecs[i].din;
            read_en = vecs[i].re; clear_err = vecs[i].ce;
            tick();
            chk_main($sformatf("v%0d", i), vecs[i].cnt, vecs[i].dout, vecs[i].dv, vecs[i].ovf, vecs[i].udf);
        end
        write_en = 1'b0; read_en = 1'b0; clear_err = 1'b0;

        // asynchronous reset mid-period, then a write in the release cycle
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            write_en = 1'b1; data_in = 8'(8'hA0 + i);
            tick();
        end
        write_en = 1'b0; read_en = 1'b1;
        tick();
        read_en = 1'b0;
        chk_main("pre_rst", 5, 8'hA0, 1, 0, 0);
        #3 rst_n = 1'b0;
        #1 chk_main("async_rst", 0, 8'h00, 0, 0, 0);
        tick();
        write_en = 1'b1; data_in = 8'hBB; rst_n = 1'b1;
        tick();
        chk_main("release_ignored", 0, 8'h00, 0, 0, 0);
        tick();
        write_en = 1'b0;
        chk_main("post_release", 1, 8'h00, 0, 0, 0);

        // 32-bit x 64-deep instance
        chk("d2 idle count", 64'(count2), 64'd0);
        chk("d2 idle almost_empty", 64'(ae2), 64'd1);
        for (int k = 1; k <= 64; k++) begin
            we2 = 1'b1; din2 = 32'hA500_0000 + 32'(k - 1);
            tick();
            chk($sformatf("d2 w%0d count", k), 64'(count2), 64'(k));
            chk($sformatf("d2 w%0d full", k), 64'(full2), 64'(k == 64));
            chk($sformatf("d2 w%0d almost_full", k), 64'(af2), 64'(k >= 60));
            chk($sformatf("d2 w%0d almost_empty", k), 64'(ae2), 64'd0);
        end
        din2 = 32'hDEAD_BEEF;
        tick();
        we2 = 1'b0;
        chk("d2 overfill count", 64'(count2), 64'd64);
        chk("d2 overflow", 64'(ovf2), 64'd1);
        for (int k = 1; k <= 64; k++) begin
            re2 = 1'b1;
            tick();
            chk($sformatf("d2 r%0d data_out", k), 64'(dout2), 64'(32'hA500_0000 + 32'(k - 1)));
            chk($sformatf("d2 r%0d data_valid", k), 64'(dv2), 64'd1);
            chk($sformatf("d2 r%0d count", k), 64'(count2), 64'(64 - k));
            chk($sformatf("d2 r%0d almost_full", k), 64'(af2), 64'((64 - k) >= 60));
            chk($sformatf("d2 r%0d almost_empty", k), 64'(ae2), 64'(k == 64));
            chk($sformatf("d2 r%0d empty", k), 64'(empty2), 64'(k == 64));
        end
        re2 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            we2 = 1'b1; din2 = 32'h100 + 32'(i);
            tick();
        end
        re2 = 1'b1;
        for (int j = 0; j < 140; j++) begin
            din2 = 32'h108 + 32'(j);
            tick();
            chk($sformatf("d2 s%0d count", j), 64'(count2), 64'd8);
            chk($sformatf("d2 s%0d data_out", j), 64'(dout2), 64'(32'h100 + 32'(j)));
        end
        we2 = 1'b0; re2 = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
